// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: one request channel and one response strobe.
// Request channel: the master raises mem_req_valid_o with we/addr/wdata/be and holds all of them
// unchanged until a cycle where mem_req_ready_i is high, and that rising edge is the transfer. Valid
// is never withdrawn before the transfer. The response is a single-cycle mem_rsp_valid_i strobe with
// no back-pressure.
interface load_store_unit_if;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_req_we_o;
  logic [31:0] mem_req_addr_o;
  logic [31:0] mem_req_wdata_o;
  logic [3:0]  mem_req_be_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_rdata_i;

  modport master (
    output mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_be_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i
  );

  modport slave (
    input  mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_be_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit. It turns an ID/EX access into a word-aligned bus request
// and, for a load, a register writeback. state_dbg_o encodes IDLE=0, REQ=1, WAIT=2, WB=3.
module load_store_unit (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_access_i,
  input  logic               store_access_i,
  input  logic [31:0]        load_addr_i,
  input  logic [31:0]        store_addr_i,
  input  logic [31:0]        store_data_i,
  input  logic [2:0]         funct3_i,
  input  logic [4:0]         rd_i,
  output logic               busy_o,
  load_store_unit_if.master  mem,
  output logic               wb_valid_o,
  output logic [4:0]         wb_rd_o,
  output logic [31:0]        wb_data_o,
  output logic               misalign_o,
  output logic [1:0]         state_dbg_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, WB = 2'd3} state_t;

  state_t      state;
  logic [1:0]  cap_ofs;
  logic [2:0]  cap_funct3;
  logic [4:0]  cap_rd;
  logic        cap_load;

  logic        req_present;
  logic        req_load;
  logic        req_legal;
  logic        req_misaligned;
  logic        req_accept;
  logic [31:0] req_addr;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] rsp_shift;
  logic [31:0] rsp_ext;

  // A simultaneous load and store is handled as the load alone.
  always_comb begin
    req_present    = load_access_i | store_access_i;
    req_load       = load_access_i;
    req_addr       = load_access_i ? load_addr_i : store_addr_i;
    if (load_access_i)
      req_legal = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      req_legal = store_access_i && (funct3_i inside {3'b000, 3'b001, 3'b010});
    req_misaligned = ((funct3_i[1:0] == 2'b01) && req_addr[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_accept     = (state == IDLE) && req_present && req_legal && !req_misaligned;
    busy_o         = (state == REQ) || (state == WAIT) || req_accept;
  end

  always_comb begin
    fmt_be    = 4'b1111;
    fmt_wdata = 32'd0;
    if (!req_load) begin
      case (funct3_i[1:0])
        2'b00: begin
          fmt_be    = 4'b0001 << req_addr[1:0];
          fmt_wdata = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          fmt_be    = req_addr[1] ? 4'b1100 : 4'b0011;
          fmt_wdata = {2{store_data_i[15:0]}};
        end
        default: fmt_wdata = store_data_i;
      endcase
    end
  end

  // Halfword offsets are always 0 or 2, so one shift serves both byte and half lanes.
  always_comb begin
    rsp_shift = mem.mem_rsp_rdata_i >> {cap_ofs, 3'b000};
    case (cap_funct3)
      3'b000:  rsp_ext = {{24{rsp_shift[7]}}, rsp_shift[7:0]};
      3'b100:  rsp_ext = {24'd0, rsp_shift[7:0]};
      3'b001:  rsp_ext = {{16{rsp_shift[15]}}, rsp_shift[15:0]};
      3'b101:  rsp_ext = {16'd0, rsp_shift[15:0]};
      default: rsp_ext = mem.mem_rsp_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      cap_ofs             <= 2'd0;
      cap_funct3          <= 3'd0;
      cap_rd              <= 5'd0;
      cap_load            <= 1'b0;
      mem.mem_req_valid_o <= 1'b0;
      mem.mem_req_we_o    <= 1'b0;
      mem.mem_req_addr_o  <= 32'd0;
      mem.mem_req_wdata_o <= 32'd0;
      mem.mem_req_be_o    <= 4'd0;
      wb_valid_o          <= 1'b0;
      wb_rd_o             <= 5'd0;
      wb_data_o           <= 32'd0;
      misalign_o          <= 1'b0;
    end else begin
      misalign_o <= (state == IDLE) && req_present && req_legal && req_misaligned;
      wb_valid_o <= 1'b0;
      wb_rd_o    <= 5'd0;
      case (state)
        IDLE: begin
          if (req_accept) begin
            cap_ofs             <= req_addr[1:0];
            cap_funct3          <= funct3_i;
            cap_rd              <= rd_i;
            cap_load            <= req_load;
            mem.mem_req_valid_o <= 1'b1;
            mem.mem_req_we_o    <= !req_load;
            mem.mem_req_addr_o  <= {req_addr[31:2], 2'b00};
            mem.mem_req_wdata_o <= fmt_wdata;
            mem.mem_req_be_o    <= fmt_be;
            state               <= REQ;
          end
        end
        REQ: begin
          if (mem.mem_req_ready_i) begin
            mem.mem_req_valid_o <= 1'b0;
            mem.mem_req_we_o    <= 1'b0;
            mem.mem_req_addr_o  <= 32'd0;
            mem.mem_req_wdata_o <= 32'd0;
            mem.mem_req_be_o    <= 4'd0;
            state               <= cap_load ? WAIT : IDLE;
          end
        end
        WAIT: begin
          if (mem.mem_rsp_valid_i) begin
            wb_data_o  <= rsp_ext;
            wb_valid_o <= 1'b1;
            wb_rd_o    <= cap_rd;
            state      <= WB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg_o = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases followed by randomized accesses, all checked against
// a byte-lane arithmetic model of the access rules.
module tb_load_store_unit;
  logic        clk;
  logic        rst_n;
  logic        load_access_i;
  logic        store_access_i;
  logic [31:0] load_addr_i;
  logic [31:0] store_addr_i;
  logic [31:0] store_data_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic        busy_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;
  logic [1:0]  state_dbg_o;

  load_store_unit_if mem_if ();

  load_store_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_access_i  (load_access_i),
    .store_access_i (store_access_i),
    .load_addr_i    (load_addr_i),
    .store_addr_i   (store_addr_i),
    .store_data_i   (store_data_i),
    .funct3_i       (funct3_i),
    .rd_i           (rd_i),
    .busy_o         (busy_o),
    .mem            (mem_if.master),
    .wb_valid_o     (wb_valid_o),
    .wb_rd_o        (wb_rd_o),
    .wb_data_o      (wb_data_o),
    .misalign_o     (misalign_o),
    .state_dbg_o    (state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  exp_rd_q[$];
  logic [31:0] last_wb = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_legal(input bit ld, input bit st, input logic [2:0] f3);
    if (ld) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (st) return f3 inside {3'd0, 3'd1, 3'd2};
    return 1'b0;
  endfunction

  function automatic int unsigned access_bytes(input logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic logic [3:0] model_store_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned n;
    int unsigned lanes;
    n     = access_bytes(f3);
    lanes = ((32'd1 << n) - 1) << (a % 4);
    return lanes[3:0];
  endfunction

  function automatic logic [31:0] model_store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (access_bytes(f3))
      1:       return (d & 32'h0000_00FF) * 32'h0101_0101;
      2:       return (d & 32'h0000_FFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] v;
    logic [31:0] mask;
    int unsigned n;
    n = access_bytes(f3);
    if (n == 4) return w;
    mask = (32'd1 << (8 * n)) - 1;
    v    = (w >> (8 * (a % 4))) & mask;
    if (!f3[2] && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    load_access_i  = 1'b0;
    store_access_i = 1'b0;
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns just after a rising edge.
  // With overlap set, the next load (LW 0x5000, rd 7) is already presented during WB.
  task automatic run_txn(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] la, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [4:0] rd, input int rdy_dly, input int rsp_dly,
                         input logic [31:0] rdata, input bit overlap);
    bit          legal;
    bit          aligned;
    bit          go;
    bit          mis;
    logic [31:0] a;
    a       = ld ? la : sa;
    legal   = model_legal(ld, st, f3);
    aligned = (a % access_bytes(f3)) == 0;
    go      = (ld || st) && legal && aligned;
    mis     = (ld || st) && legal && !aligned;

    load_access_i  = ld;
    store_access_i = st;
    load_addr_i    = la;
    store_addr_i   = sa;
    store_data_i   = sd;
    funct3_i       = f3;
    rd_i           = rd;
    @(negedge clk);
    check_eq("t0_busy", busy_o, go);
    check_eq("t0_req_valid", mem_if.mem_req_valid_o, 0);
    check_eq("t0_misalign", misalign_o, 0);
    @(posedge clk); #1;
    idle_inputs();

    if (!go) begin
      @(negedge clk);
      check_eq("t1_misalign", misalign_o, mis);
      check_eq("t1_req_valid", mem_if.mem_req_valid_o, 0);
      check_eq("t1_busy", busy_o, 0);
      @(posedge clk); #1;
      if (mis) begin
        @(negedge clk);
        check_eq("t2_misalign_clear", misalign_o, 0);
        check_eq("t2_wb_valid", wb_valid_o, 0);
        @(posedge clk); #1;
      end
      return;
    end

    for (int c = 0; c <= rdy_dly; c++) begin
      mem_if.mem_req_ready_i = (c == rdy_dly);
      mem_if.mem_rsp_valid_i = 1'($urandom_range(0, 1));
      mem_if.mem_rsp_rdata_i = $urandom;
      @(negedge clk);
      check_eq("req_valid", mem_if.mem_req_valid_o, 1);
      check_eq("req_addr", mem_if.mem_req_addr_o, a & ~32'd3);
      check_eq("req_we", mem_if.mem_req_we_o, !ld);
      check_eq("req_be", mem_if.mem_req_be_o, ld ? 4'hF : model_store_be(f3, a));
      if (!ld) check_eq("req_wdata", mem_if.mem_req_wdata_o, model_store_wdata(f3, sd));
      check_eq("req_busy", busy_o, 1);
      check_eq("req_wb_valid", wb_valid_o, 0);
      @(posedge clk); #1;
    end
    mem_if.mem_req_ready_i = 1'b0;
    mem_if.mem_rsp_valid_i = 1'b0;

    if (!ld) begin
      @(negedge clk);
      check_eq("st_done_valid", mem_if.mem_req_valid_o, 0);
      check_eq("st_done_busy", busy_o, 0);
      check_eq("st_done_wb_valid", wb_valid_o, 0);
      @(posedge clk); #1;
      return;
    end

    exp_q.push_back(model_load(f3, a, rdata));
    exp_rd_q.push_back(rd);
    for (int c = 0; c < rsp_dly; c++) begin
      @(negedge clk);
      check_eq("wait_busy", busy_o, 1);
      check_eq("wait_req_valid", mem_if.mem_req_valid_o, 0);
      check_eq("wait_wb_valid", wb_valid_o, 0);
      @(posedge clk); #1;
    end
    mem_if.mem_rsp_valid_i = 1'b1;
    mem_if.mem_rsp_rdata_i = rdata;
    @(negedge clk);
    check_eq("rsp_busy", busy_o, 1);
    @(posedge clk); #1;
    // A response strobe during WB must not disturb the writeback data.
    mem_if.mem_rsp_valid_i = 1'($urandom_range(0, 1));
    mem_if.mem_rsp_rdata_i = $urandom;
    if (overlap) begin
      load_access_i = 1'b1;
      load_addr_i   = 32'h0000_5000;
      funct3_i      = 3'b010;
      rd_i          = 5'd7;
    end
    @(negedge clk);
    check_eq("wb_valid", wb_valid_o, 1);
    check_eq("wb_busy", busy_o, 0);
    check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      last_wb = exp_q.pop_front();
      check_eq("wb_data", wb_data_o, last_wb);
      check_eq("wb_rd", wb_rd_o, exp_rd_q.pop_front());
    end
    @(posedge clk); #1;
    mem_if.mem_rsp_valid_i = 1'b0;
    if (overlap) return;
    @(negedge clk);
    check_eq("wb_valid_clear", wb_valid_o, 0);
    check_eq("wb_rd_clear", wb_rd_o, 0);
    check_eq("wb_data_hold", wb_data_o, last_wb);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n                  = 1'b0;
    idle_inputs();
    load_addr_i            = 32'd0;
    store_addr_i           = 32'd0;
    store_data_i           = 32'd0;
    funct3_i               = 3'd0;
    rd_i                   = 5'd0;
    mem_if.mem_req_ready_i = 1'b0;
    mem_if.mem_rsp_valid_i = 1'b0;
    mem_if.mem_rsp_rdata_i = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", state_dbg_o, 0);
    check_eq("rst_req_valid", mem_if.mem_req_valid_o, 0);
    check_eq("rst_req_addr", mem_if.mem_req_addr_o, 0);
    check_eq("rst_wb_valid", wb_valid_o, 0);
    check_eq("rst_wb_data", wb_data_o, 0);
    check_eq("rst_misalign", misalign_o, 0);
    check_eq("rst_busy", busy_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // LB with sign extension from the top byte lane
    run_txn(1, 0, 3'b000, 32'h0000_1003, 0, 0, 5'd5, 0, 0, 32'h80FF_0000, 0);
    // SH to upper half
    run_txn(0, 1, 3'b001, 0, 32'h0000_2002, 32'h0000_BEEF, 5'd0, 0, 0, 0, 0);
    // misaligned LW
    run_txn(1, 0, 3'b010, 32'h0000_3001, 0, 0, 5'd3, 0, 0, 0, 0);
    // SW stalled four cycles
    run_txn(0, 1, 3'b010, 0, 32'h4444_0008, 32'hCAFE_F00D, 5'd0, 4, 0, 0, 0);
    // LHU, then a load presented during WB that must wait for IDLE
    run_txn(1, 0, 3'b101, 32'h0000_4002, 0, 0, 5'd9, 0, 0, 32'hA5A5_1234, 1);
    run_txn(1, 0, 3'b010, 32'h0000_5000, 0, 0, 5'd7, 0, 1, 32'h1357_9BDF, 0);
    // load with rd=0 and both access lines high
    run_txn(1, 1, 3'b100, 32'h0000_6001, 32'h0000_7000, 32'hFFFF_FFFF, 5'd0, 1, 2, 32'h00C3_0000, 0);
    // illegal store code
    run_txn(0, 1, 3'b100, 0, 32'h0000_8000, 32'h1, 5'd0, 0, 0, 0, 0);

    // reset during WAIT, then a stale response
    load_access_i = 1'b1;
    load_addr_i   = 32'h0000_9000;
    funct3_i      = 3'b010;
    rd_i          = 5'd12;
    @(posedge clk); #1;
    idle_inputs();
    mem_if.mem_req_ready_i = 1'b1;
    @(posedge clk); #1;
    mem_if.mem_req_ready_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_state", state_dbg_o, 0);
    check_eq("midrst_busy", busy_o, 0);
    check_eq("midrst_req_valid", mem_if.mem_req_valid_o, 0);
    @(posedge clk); #1;
    rst_n                  = 1'b1;
    mem_if.mem_rsp_valid_i = 1'b1;
    mem_if.mem_rsp_rdata_i = 32'hFFFF_FFFF;
    last_wb                = 32'd0;
    @(posedge clk); #1;
    mem_if.mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    check_eq("postrst_wb_valid", wb_valid_o, 0);
    check_eq("postrst_wb_data", wb_data_o, 0);
    check_eq("postrst_state", state_dbg_o, 0);
    check_eq("postrst_busy", busy_o, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 120; i++) begin
      int          kind;
      bit          ld;
      bit          st;
      logic [31:0] addr;
      kind = $urandom_range(0, 9);
      ld   = (kind <= 3) || (kind == 8);
      st   = (kind >= 4) && (kind <= 8);
      addr = $urandom;
      if ($urandom_range(0, 2) == 0) addr[1:0] = 2'b00;
      run_txn(ld, st, 3'($urandom_range(0, 7)), addr, addr ^ 32'h0000_0100, $urandom,
              5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom, 0);
    end

    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
